seg7_scan: RTL and testbench



---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_hex_decode.sv | 17 +
 rtl/seg7_scan.sv | 146 ++++++++++++++
 tb/tb_seg7_scan.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: segment bit
// positions, the hex glyph table and the all-dark pattern.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Entry n is the active-high {g,f,e,d,c,b,a} glyph for nibble n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble + decimal point to active-high segment pattern.
// Zero latency; no flow control.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg                = SEG_BLANK;
        seg[SEG_G:SEG_A]   = HEX_SEG[nibble];
        seg[SEG_DP]        = dp;
    end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment driver with frame-synchronous double buffering,
// leading-zero blanking and PWM dimming; pins are registered (1-cycle latency).
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV_LOG2  = 17,
    parameter int BRIGHT_BITS    = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]         IDX_ONE  = 1;
    localparam logic [SCAN_DIV_LOG2-1:0] PS_ONE   = 1;
    localparam logic [7:0]               SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0]    AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [SCAN_DIV_LOG2-1:0] prescaler;
    logic [IDX_W-1:0]         idx;

    logic [4*NUM_DIGITS-1:0]  pend_data, act_data;
    logic [NUM_DIGITS-1:0]    pend_dp, act_dp;
    logic [NUM_DIGITS-1:0]    pend_en, act_en;
    logic                     pend_lz, act_lz;
    logic                     pend_vld;

    logic                     slot_end;
    logic                     frame_end;

    assign slot_end  = &prescaler;
    assign frame_end = slot_end && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler  <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
            pend_vld   <= 1'b0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_en    <= '1;
            pend_lz    <= 1'b0;
            act_data   <= '0;
            act_dp     <= '0;
            act_en     <= '1;
            act_lz     <= 1'b0;
        end else begin
            prescaler  <= prescaler + PS_ONE;
            frame_tick <= frame_end;
            if (slot_end) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_ONE;
            end
            // Active set only changes at the frame seam; a load landing on
            // the seam itself goes straight through.
            if (frame_end) begin
                if (load) begin
                    act_data <= data;
                    act_dp   <= dp;
                    act_en   <= digit_en;
                    act_lz   <= lz_blank;
                end else if (pend_vld) begin
                    act_data <= pend_data;
                    act_dp   <= pend_dp;
                    act_en   <= pend_en;
                    act_lz   <= pend_lz;
                end
                pend_vld <= 1'b0;
            end else if (load) begin
                pend_data <= data;
                pend_dp   <= dp;
                pend_en   <= digit_en;
                pend_lz   <= lz_blank;
                pend_vld  <= 1'b1;
            end
        end
    end

    // zero_above[i]: every enabled digit from i upward is a bare zero.
    logic [NUM_DIGITS:0]   zero_above;
    logic [NUM_DIGITS-1:0] visible;
    logic [NUM_DIGITS-1:0] an_hot;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_vis;

    always_comb begin
        zero_above             = '0;
        visible                = '0;
        an_hot                 = '0;
        cur_nib                = 4'h0;
        cur_dp                 = 1'b0;
        cur_vis                = 1'b0;
        zero_above[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above[i] = zero_above[i+1] &&
                            (!act_en[i] || (act_data[4*i +: 4] == 4'h0 && !act_dp[i]));
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            visible[i] = act_en[i] && !(act_lz && (i != 0) && zero_above[i]);
            if (idx == IDX_W'(i)) begin
                an_hot[i] = 1'b1;
                cur_nib   = act_data[4*i +: 4];
                cur_dp    = act_dp[i];
                cur_vis   = visible[i];
            end
        end
    end

    logic [7:0] dec_seg;
    logic       lit;

    seg7_hex_decode u_dec (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .seg    (dec_seg)
    );

    assign lit = cur_vis &&
                 (prescaler[SCAN_DIV_LOG2-1 -: BRIGHT_BITS] <= brightness);

    // Unlit cycles drive both buses fully off so nothing ghosts across slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= (lit ? dec_seg : SEG_BLANK) ^ SEG_OFF;
            an  <= (lit ? an_hot : '0) ^ AN_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: 4 digits, 16-cycle slots, 2-bit brightness,
// plus an active-high polarity instance sharing the same stimulus.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic [1:0]  brightness;
    logic [7:0]  seg, seg2;
    logic [3:0]  an, an2;
    logic        frame_tick, frame_tick2;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;
    exp_t exp_q[$];

    logic [3:0] cap_an  [64];
    logic [3:0] cap_an2 [64];
    logic [7:0] cap_seg [64];
    logic [7:0] cap_seg2[64];
    logic       cap_tick[64];

    always #5 clk = ~clk;

    seg7_scan #(
        .NUM_DIGITS(4), .SCAN_DIV_LOG2(4), .BRIGHT_BITS(2),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .data(data), .dp(dp),
        .digit_en(digit_en), .lz_blank(lz_blank), .brightness(brightness),
        .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    seg7_scan #(
        .NUM_DIGITS(4), .SCAN_DIV_LOG2(4), .BRIGHT_BITS(2),
        .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
    ) dut_hi (
        .clk(clk), .rst(rst), .load(load), .data(data), .dp(dp),
        .digit_en(digit_en), .lz_blank(lz_blank), .brightness(brightness),
        .seg(seg2), .an(an2), .frame_tick(frame_tick2)
    );

    task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                           input logic [3:0] en, input logic lz);
        data = d; dp = p; digit_en = en; lz_blank = lz; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Expected active-low pins for digit k; glyph is active-high.
    task automatic push_digit(input int k, input logic [7:0] glyph, input logic on);
        exp_t e;
        e.an  = on ? ~(4'b0001 << k) : 4'hF;
        e.seg = on ? ~glyph : 8'hFF;
        exp_q.push_back(e);
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 200);
        total++;
        if (frame_tick !== 1'b1) begin
            bad++;
            $display("FAIL frame_wait: no frame_tick within %0d cycles", n);
        end
    endtask

    // Entry c holds the pins for digit c/16 at prescaler c%16.
    task automatic capture_frame(input bit at_tick);
        if (!at_tick) wait_frame();
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            cap_an[c]   = an;
            cap_seg[c]  = seg;
            cap_an2[c]  = an2;
            cap_seg2[c] = seg2;
            cap_tick[c] = frame_tick;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; data = '0; dp = '0; digit_en = 4'hF;
        lz_blank = 1'b0; brightness = 2'd3;
        repeat (3) @(negedge clk);
        total++;
        if (seg !== 8'hFF || an !== 4'hF || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_low: seg=%h an=%h tick=%b want seg=ff an=f tick=0", seg, an, frame_tick);
        end
        total++;
        if (seg2 !== 8'h00 || an2 !== 4'h0 || frame_tick2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_high: seg=%h an=%h tick=%b want seg=00 an=0 tick=0", seg2, an2, frame_tick2);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (seg !== 8'hC0 || an !== 4'hE) begin
            bad++;
            $display("FAIL reset_first_digit: seg=%h an=%h want seg=c0 an=e", seg, an);
        end
    endtask

    task automatic test_decode();
        exp_t e;
        int ticks = 0;
        do_load(16'h12A0, 4'h0, 4'hF, 1'b0);
        push_digit(0, 8'h3F, 1'b1);
        push_digit(1, 8'h77, 1'b1);
        push_digit(2, 8'h5B, 1'b1);
        push_digit(3, 8'h06, 1'b1);
        capture_frame(1'b0);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            total++;
            if (cap_an[16*k+8] !== e.an || cap_seg[16*k+8] !== e.seg) begin
                bad++;
                $display("FAIL decode_digit%0d: an=%h seg=%h want an=%h seg=%h",
                         k, cap_an[16*k+8], cap_seg[16*k+8], e.an, e.seg);
            end
        end
        for (int c = 0; c < 64; c++) ticks += int'(cap_tick[c]);
        total++;
        if (ticks != 1 || cap_tick[63] !== 1'b1) begin
            bad++;
            $display("FAIL frame_period: ticks=%0d last=%b want ticks=1 last=1", ticks, cap_tick[63]);
        end
    endtask

    task automatic test_lz_blank();
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                do_load(16'h0005, 4'b0000, 4'hF, 1'b1);
                push_digit(0, 8'h6D, 1'b1);
                push_digit(1, 8'h00, 1'b0);
                push_digit(2, 8'h00, 1'b0);
                push_digit(3, 8'h00, 1'b0);
            end else begin
                do_load(16'h0005, 4'b0100, 4'hF, 1'b1);
                push_digit(0, 8'h6D, 1'b1);
                push_digit(1, 8'h3F, 1'b1);
                push_digit(2, 8'hBF, 1'b1);
                push_digit(3, 8'h00, 1'b0);
            end
            capture_frame(1'b0);
            for (int k = 0; k < 4; k++) begin
                e = exp_q.pop_front();
                total++;
                if (cap_an[16*k+8] !== e.an || cap_seg[16*k+8] !== e.seg) begin
                    bad++;
                    $display("FAIL lz_pass%0d_digit%0d: an=%h seg=%h want an=%h seg=%h",
                             pass, k, cap_an[16*k+8], cap_seg[16*k+8], e.an, e.seg);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        wait_frame();
        repeat (10) @(negedge clk);
        do_load(16'h1111, 4'h0, 4'hF, 1'b0);
        repeat (10) @(negedge clk);
        do_load(16'h2222, 4'h0, 4'hF, 1'b0);
        // Digit 3 of the frame already in progress must still be the old (blank) value.
        push_digit(3, 8'h00, 1'b0);
        repeat (36) @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (an !== e.an || seg !== e.seg) begin
            bad++;
            $display("FAIL old_frame_digit3: an=%h seg=%h want an=%h seg=%h", an, seg, e.an, e.seg);
        end
        for (int k = 0; k < 4; k++) push_digit(k, 8'h5B, 1'b1);
        capture_frame(1'b0);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            total++;
            if (cap_an[16*k+8] !== e.an || cap_seg[16*k+8] !== e.seg) begin
                bad++;
                $display("FAIL last_load_wins_digit%0d: an=%h seg=%h want an=%h seg=%h",
                         k, cap_an[16*k+8], cap_seg[16*k+8], e.an, e.seg);
            end
        end
        // Land a load exactly on the frame boundary cycle.
        wait_frame();
        repeat (63) @(negedge clk);
        do_load(16'h3333, 4'h0, 4'hF, 1'b0);
        total++;
        if (frame_tick !== 1'b1) begin
            bad++;
            $display("FAIL boundary_align: tick=%b want 1", frame_tick);
        end
        for (int k = 0; k < 4; k++) push_digit(k, 8'h4F, 1'b1);
        capture_frame(1'b1);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            total++;
            if (cap_an[16*k+8] !== e.an || cap_seg[16*k+8] !== e.seg) begin
                bad++;
                $display("FAIL boundary_load_digit%0d: an=%h seg=%h want an=%h seg=%h",
                         k, cap_an[16*k+8], cap_seg[16*k+8], e.an, e.seg);
            end
        end
    endtask

    task automatic test_pwm();
        logic [1:0] levels[3];
        int         want[3];
        levels[0] = 2'd0; levels[1] = 2'd1; levels[2] = 2'd3;
        want[0] = 4; want[1] = 8; want[2] = 16;
        for (int b = 0; b < 3; b++) begin
            brightness = levels[b];
            capture_frame(1'b0);
            for (int k = 0; k < 4; k++) begin
                int on_cnt = 0;
                int early  = 0;
                for (int p = 0; p < 16; p++) begin
                    if (cap_an[16*k+p] !== 4'hF) begin
                        on_cnt++;
                        if (p < want[b]) early++;
                    end
                end
                total++;
                if (on_cnt != want[b] || early != want[b]) begin
                    bad++;
                    $display("FAIL pwm_b%0d_digit%0d: lit=%0d leading=%0d want %0d",
                             levels[b], k, on_cnt, early, want[b]);
                end
            end
        end
        brightness = 2'd3;
    endtask

    task automatic test_enable_polarity();
        exp_t e;
        do_load(16'h0000, 4'h0, 4'b0101, 1'b0);
        push_digit(0, 8'h3F, 1'b1);
        push_digit(1, 8'h00, 1'b0);
        push_digit(2, 8'h3F, 1'b1);
        push_digit(3, 8'h00, 1'b0);
        capture_frame(1'b0);
        for (int k = 0; k < 4; k++) begin
            int lit_cnt = 0;
            e = exp_q.pop_front();
            for (int p = 0; p < 16; p++)
                if (cap_an[16*k+p] !== 4'hF || cap_seg[16*k+p] !== 8'hFF) lit_cnt++;
            total++;
            if (cap_an[16*k+8] !== e.an || cap_seg[16*k+8] !== e.seg ||
                (e.an == 4'hF && lit_cnt != 0)) begin
                bad++;
                $display("FAIL enable_digit%0d: an=%h seg=%h lit=%0d want an=%h seg=%h",
                         k, cap_an[16*k+8], cap_seg[16*k+8], lit_cnt, e.an, e.seg);
            end
        end
        total++;
        if (cap_an2[8] !== 4'b0001 || cap_seg2[8] !== 8'h3F) begin
            bad++;
            $display("FAIL polarity_lit: an=%h seg=%h want an=1 seg=3f", cap_an2[8], cap_seg2[8]);
        end
        total++;
        if (cap_an2[24] !== 4'b0000 || cap_seg2[24] !== 8'h00) begin
            bad++;
            $display("FAIL polarity_dark: an=%h seg=%h want an=0 seg=00", cap_an2[24], cap_seg2[24]);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        wait_frame();
        repeat (20) @(negedge clk);
        do_load(16'h7777, 4'h0, 4'hF, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (seg !== 8'hFF || an !== 4'hF || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs: seg=%h an=%h tick=%b want seg=ff an=f tick=0", seg, an, frame_tick);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (seg !== 8'hC0 || an !== 4'hE) begin
            bad++;
            $display("FAIL midreset_index0: seg=%h an=%h want seg=c0 an=e", seg, an);
        end
        for (int k = 0; k < 4; k++) push_digit(k, 8'h3F, 1'b1);
        capture_frame(1'b0);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            total++;
            if (cap_an[16*k+8] !== e.an || cap_seg[16*k+8] !== e.seg) begin
                bad++;
                $display("FAIL pending_discard_digit%0d: an=%h seg=%h want an=%h seg=%h",
                         k, cap_an[16*k+8], cap_seg[16*k+8], e.an, e.seg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_lz_blank();
        test_back_to_back();
        test_pwm();
        test_enable_polarity();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
